matrix_c_drain: RTL
===================

# matrix_c_drain

Result-side collector for the systolic matrix multiplier: the operand FIFOs shift rows into the array, and this block captures the diagonally skewed result lanes leaving it. It de-skews them into a DEPTH×DEPTH result buffer and then serves random-access element reads by row/column to the host/controller. It is the drain end of the same transposed-load/shift interface the operand FIFOs feed.

## Interface
- DEPTH, 8, matrix dimension and number of result lanes
- BITS, 8, operand width
- OBITS, 2*BITS+$clog2(DEPTH), signed result width per element
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin capture of a new result matrix
- in_valid  input  1  array result beat present on din this cycle
- din  input  [OBITS-1:0] x DEPTH (signed, unpacked)  lane j = array column j output
- busy  output  1  high while in CAPTURE
- done  output  1  one-cycle pulse when the last beat is written
- rd_en  input  1  read request
- rd_row  input  $clog2(DEPTH)  read row address
- rd_col  input  $clog2(DEPTH)  read column address
- rd_data  output  signed [OBITS-1:0]  registered read data
- rd_valid  output  1  rd_data valid this cycle

## Operation
- States: IDLE, CAPTURE, READY.
- IDLE/READY + start → CAPTURE; beat counter cnt ← 0. start while in CAPTURE is ignored.
- CAPTURE: each cycle with in_valid accepts one beat; in_valid low stalls (cnt holds, nothing written).
- Skew rule: on beat cnt=k, lane j writes buf[k−j][j] when 0 ≤ k−j ≤ DEPTH−1; other lanes are ignored.
- Total 2*DEPTH−1 beats. On the beat with k = 2*DEPTH−2 → READY; done pulses on the following cycle, with busy low on that cycle.
- start is not required to clear the buffer; every cell is overwritten during a full capture.
- READY: rd_en reads buf[rd_row][rd_col]. rd_en in IDLE or CAPTURE is ignored (rd_valid stays 0).
- start and rd_en in the same READY cycle: the read is served from the pre-capture contents, then the block enters CAPTURE.
- Reset at any time, including mid-capture: state IDLE, cnt 0, all buffer cells 0, and outputs busy=0, done=0, rd_valid=0, rd_data=0. No partial-capture data survives.
- No arithmetic other than the optional clamp; din is stored at full OBITS width.

## Timing
- Capture latency: the last accepted beat at cycle t → done=1 at t+1 → reads accepted from t+1.
- Read latency: rd_en at cycle t → rd_data and rd_valid at t+1. Back-to-back reads at one per cycle.
- rd_data holds its last value when rd_valid=0.
- busy goes high the cycle after start is sampled.

## Configuration
- MATC_RELU_EN defined: rd_data = 0 when the stored element is negative; otherwise the stored value. The buffer always holds the raw value.
- MATC_RELU_EN undefined: rd_data is the raw stored value.
- The macro has no effect on capture timing or read latency.

## Structure
- Shared package matmul_pkg: state enum (IDLE/CAPTURE/READY) and the OBITS width function, shared with the controller.
- One sub-module, matrix_c_buf: the DEPTH×DEPTH register array with a per-lane write port (row index, enable) and one registered read port. The FSM, counter and skew decode stay in the top.

## Test plan
- DEPTH=4, rst asserted mid-CAPTURE after 3 beats → all outputs 0; a subsequent read after a full capture returns only new data.
- DEPTH=4, start, then 7 contiguous beats where lane j at beat k carries 10*(k−j)+j → done on cycle 8; reading (2,3) returns 23, and reading every cell returns 10*r+c.
- Same stimulus with in_valid toggling 1,0,1,0 → identical buffer contents; done is delayed by the stall count.
- rd_en during CAPTURE at (0,0) → rd_valid stays 0. start during CAPTURE → ignored, and done still occurs after 7 beats.
- In READY, start and rd_en (1,1) in the same cycle → returns the old value 11, then busy rises.
- MATC_RELU_EN, stored −5 at (3,0) → reads 0. Without the macro → reads −5 (sign-extended OBITS).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared matmul types: FSM states used by the controller and the result drain,
// plus the result-element width rule.
package matmul_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCapture,
      StReady
   } matmul_state_e;

   function automatic int unsigned obits_f(input int unsigned depth, input int unsigned bits);
      return 2 * bits + $clog2(depth);
   endfunction

endpackage

// File: rtl/matrix_c_buf.sv
// DEPTH x DEPTH result register array: one write port per lane (column j) and one
// registered read port. MATC_RELU_EN clamps negative read data to zero.
module matrix_c_buf #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned OBITS = 19,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DEPTH-1:0]        we,
   input  logic [AW-1:0]           wrow  [DEPTH],
   input  logic signed [OBITS-1:0] wdata [DEPTH],
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_row,
   input  logic [AW-1:0]           rd_col,
   output logic signed [OBITS-1:0] rd_data,
   output logic                    rd_valid
);

   logic signed [OBITS-1:0] mem_q [DEPTH][DEPTH];
   logic signed [OBITS-1:0] rd_data_d, rd_data_q;
   logic                    rd_valid_q;

   // Lane j only ever writes column j, so lanes never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
               mem_q[r][c] <= '0;
            end
         end
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            if (we[j]) begin
               mem_q[wrow[j]][j] <= wdata[j];
            end
         end
      end
   end

   always_comb begin
      rd_data_d = mem_q[rd_row][rd_col];
`ifdef MATC_RELU_EN
      if (rd_data_d[OBITS-1]) begin
         rd_data_d = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= rd_data_d;
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/matrix_c_drain.sv
// Systolic result drain: de-skews DEPTH result lanes into a DEPTH x DEPTH buffer and
// serves element reads. Optional MATC_RELU_EN clamps negative read data to zero.
module matrix_c_drain import matmul_pkg::*; #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BITS  = 8,
   parameter int unsigned OBITS = obits_f(DEPTH, BITS),
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic signed [OBITS-1:0] din [DEPTH],
   output logic                    busy,
   output logic                    done,
   input  logic                    rd_en,
   input  logic [AW-1:0]           rd_row,
   input  logic [AW-1:0]           rd_col,
   output logic signed [OBITS-1:0] rd_data,
   output logic                    rd_valid
);

   localparam int unsigned CW = $clog2(2 * DEPTH - 1);
   localparam logic [CW-1:0] LastBeat = CW'(2 * DEPTH - 2);

   matmul_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          accept;
   logic [DEPTH-1:0] lane_we;
   logic [AW-1:0]    lane_row [DEPTH];

   assign accept = (state_q == StCapture) && in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle, StReady: begin
            if (start) begin
               state_d = StCapture;
               cnt_d   = '0;
            end
         end
         StCapture: begin
            if (in_valid) begin
               if (cnt_q == LastBeat) begin
                  state_d = StReady;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Beat k carries row k-j on lane j; lanes outside the diagonal band are dropped.
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         lane_we[j]  = 1'b0;
         lane_row[j] = '0;
         if (accept && (cnt_q >= CW'(j)) && ((cnt_q - CW'(j)) <= CW'(DEPTH - 1))) begin
            lane_we[j]  = 1'b1;
            lane_row[j] = AW'(cnt_q - CW'(j));
         end
      end
   end

   matrix_c_buf #(
      .DEPTH (DEPTH),
      .OBITS (OBITS)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .we       (lane_we),
      .wrow     (lane_row),
      .wdata    (din),
      .rd_en    (rd_en && (state_q == StReady)),
      .rd_row   (rd_row),
      .rd_col   (rd_col),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   assign busy = (state_q == StCapture);
   assign done = done_q;

endmodule
